nyancat_sprite_renderer: RTL

// - Pixel stage directly downstream of the VGA sync generator.
// - Inputs: raster coordinates, syncs and activevideo from the sync generator.
// - Reads a scaled, animated 4-bit indexed sprite from an external synchronous ROM.
// - Maps each index to 12-bit RGB and drives the VGA pins.
// - Syncs are delayed so that colour and sync leave the block co-timed.

---
 rtl/nyancat_sprite_renderer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/nyancat_sprite_renderer.sv
// Pixel stage after the VGA sync generator: scaled, animated 4-bit sprite from an external sync ROM -> 12-bit RGB.
// Optional `TEST_PATTERN_EN adds a pattern_sel input that replaces the sprite with 8 vertical colour bars.
module nyancat_sprite_renderer #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          SPRITE_W    = 64,
    parameter int          SPRITE_H    = 64,
    parameter int          SCALE_SHIFT = 2,
    parameter int          FRAMES      = 6,
    parameter int          FRAME_DIV   = 5,
    parameter logic [11:0] BG_RGB      = 12'h124,
    parameter int          X_W         = 10,
    parameter int          Y_W         = 10
) (
    input  logic           px_clk,
    input  logic           reset,
    input  logic           hsync_in,
    input  logic           vsync_in,
    input  logic [X_W-1:0] x_px,
    input  logic [Y_W-1:0] y_px,
    input  logic           activevideo,
`ifdef TEST_PATTERN_EN
    input  logic           pattern_sel,
`endif
    output logic [14:0]    rom_addr,
    input  logic [3:0]     rom_data,
    output logic           vga_hsync,
    output logic           vga_vsync,
    output logic [3:0]     vga_r,
    output logic [3:0]     vga_g,
    output logic [3:0]     vga_b,
    output logic [2:0]     frame_idx
);

    localparam int ADDR_W = 15;
    localparam int TX_W   = $clog2(SPRITE_W);
    localparam int TY_W   = $clog2(SPRITE_H);
    localparam int SPAN_X = SPRITE_W << SCALE_SHIFT;
    localparam int SPAN_Y = SPRITE_H << SCALE_SHIFT;
    localparam int X_OFS  = (H_ACTIVE - SPAN_X) / 2;
    localparam int Y_OFS  = (V_ACTIVE - SPAN_Y) / 2;
    localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    if (FRAMES * SPRITE_W * SPRITE_H > 2 ** ADDR_W) begin : g_rom_too_big
        $error("sprite ROM image does not fit in a 15-bit address");
    end

    // ---------------- S1: sprite-space coordinates and ROM address ----------------
    // Negative offsets wrap to large unsigned values, so one compare covers both bounds.
    logic [X_W:0]        w_sx;
    logic [Y_W:0]        w_sy;
    logic                w_inside;
    logic [TX_W-1:0]     w_tx;
    logic [TY_W-1:0]     w_ty;
    logic [ADDR_W-1:0]   w_addr;

    logic [ADDR_W-1:0]   r_rom_addr;
    logic [2:0]          r_frame_idx;
    logic [DIV_W-1:0]    r_div;
    logic                r_vs_prev;
    logic [2:0]          r_hs_pipe;
    logic [2:0]          r_vs_pipe;
    logic                r_s1_active, r_s1_inside;
    logic                r_s2_active, r_s2_inside;
    logic [11:0]         r_rgb;
    logic [11:0]         w_pal;
    logic [11:0]         w_rgb_next;
    logic                w_vs_fall;

    assign w_sx     = {1'b0, x_px} - (X_W + 1)'(X_OFS);
    assign w_sy     = {1'b0, y_px} - (Y_W + 1)'(Y_OFS);
    assign w_inside = activevideo && (w_sx < (X_W + 1)'(SPAN_X)) && (w_sy < (Y_W + 1)'(SPAN_Y));
    assign w_tx     = w_sx[SCALE_SHIFT +: TX_W];
    assign w_ty     = w_sy[SCALE_SHIFT +: TY_W];
    assign w_addr   = ADDR_W'(r_frame_idx) * ADDR_W'(SPRITE_W * SPRITE_H)
                    + ADDR_W'(w_ty) * ADDR_W'(SPRITE_W)
                    + ADDR_W'(w_tx);

`ifdef TEST_PATTERN_EN
    logic [X_W-1:0] w_bar_full;
    logic [2:0]     w_bar;
    logic           r_s1_pat, r_s2_pat;
    logic [2:0]     r_s1_bar, r_s2_bar;
    logic [11:0]    w_bar_rgb;

    assign w_bar_full = x_px >> 6;
    assign w_bar      = (w_bar_full > X_W'(7)) ? 3'd7 : w_bar_full[2:0];

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_s1_pat <= 1'b0;
            r_s1_bar <= 3'd0;
            r_s2_pat <= 1'b0;
            r_s2_bar <= 3'd0;
        end else begin
            r_s1_pat <= pattern_sel;
            r_s1_bar <= w_bar;
            r_s2_pat <= r_s1_pat;
            r_s2_bar <= r_s1_bar;
        end
    end

    always_comb begin
        w_bar_rgb = 12'h000;
        case (r_s2_bar)
            3'd0:    w_bar_rgb = 12'hFFF;
            3'd1:    w_bar_rgb = 12'hFF0;
            3'd2:    w_bar_rgb = 12'h0FF;
            3'd3:    w_bar_rgb = 12'h0F0;
            3'd4:    w_bar_rgb = 12'hF0F;
            3'd5:    w_bar_rgb = 12'hF00;
            3'd6:    w_bar_rgb = 12'h00F;
            default: w_bar_rgb = 12'h000;
        endcase
    end
`endif

    // NOTE: every clocked process uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_rom_addr  <= '0;
            r_s1_active <= 1'b0;
            r_s1_inside <= 1'b0;
            r_s2_active <= 1'b0;
            r_s2_inside <= 1'b0;
            r_hs_pipe   <= 3'b111;
            r_vs_pipe   <= 3'b111;
        end else begin
            if (w_inside) begin
                r_rom_addr <= w_addr;
            end
            r_s1_active <= activevideo;
            r_s1_inside <= w_inside;
            r_s2_active <= r_s1_active;
            r_s2_inside <= r_s1_inside;
            r_hs_pipe   <= {r_hs_pipe[1:0], hsync_in};
            r_vs_pipe   <= {r_vs_pipe[1:0], vsync_in};
        end
    end

    // ---------------- Animation: step the frame every FRAME_DIV vsync falls ----------------
    assign w_vs_fall = r_vs_prev && !vsync_in;

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_vs_prev   <= 1'b1;
            r_div       <= '0;
            r_frame_idx <= 3'd0;
        end else begin
            r_vs_prev <= vsync_in;
            if (w_vs_fall) begin
                if (r_div == DIV_W'(FRAME_DIV - 1)) begin
                    r_div       <= '0;
                    r_frame_idx <= (r_frame_idx == 3'(FRAMES - 1)) ? 3'd0 : r_frame_idx + 3'd1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    // ---------------- S3: palette lookup on the ROM's registered index ----------------
    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        w_pal = BG_RGB;
        case (rom_data)
            4'h0: w_pal = BG_RGB;
            4'h1: w_pal = 12'h000;
            4'h2: w_pal = 12'hFFF;
            4'h3: w_pal = 12'hFC9;
            4'h4: w_pal = 12'hF9F;
            4'h5: w_pal = 12'hF39;
            4'h6: w_pal = 12'h999;
            4'h7: w_pal = 12'hF99;
            4'h8: w_pal = 12'hF00;
            4'h9: w_pal = 12'hF90;
            4'hA: w_pal = 12'hFF0;
            4'hB: w_pal = 12'h3F0;
            4'hC: w_pal = 12'h09F;
            4'hD: w_pal = 12'h63F;
            4'hE: w_pal = 12'h666;
            4'hF: w_pal = 12'hCCC;
            default: w_pal = BG_RGB;
        endcase
    end

    always_comb begin
        w_rgb_next = 12'h000;
        if (r_s2_active) begin
            w_rgb_next = r_s2_inside ? w_pal : BG_RGB;
`ifdef TEST_PATTERN_EN
            if (r_s2_pat) begin
                w_rgb_next = w_bar_rgb;
            end
`endif
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_rgb <= 12'h000;
        end else begin
            r_rgb <= w_rgb_next;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign frame_idx = r_frame_idx;
    assign vga_hsync = r_hs_pipe[2];
    assign vga_vsync = r_vs_pipe[2];
    assign vga_r     = r_rgb[11:8];
    assign vga_g     = r_rgb[7:4];
    assign vga_b     = r_rgb[3:0];

endmodule
